// File: rtl/stage4_pkg.sv
// Shared types and defaults for the stage-4 memory-access / writeback stage.
// Optional timeout support is controlled by the MEM_TIMEOUT_EN macro.
package stage4_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int ADDR_W_DEF  = 16;
    localparam int RA_W_DEF    = 4;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic WB_RES = 1'b0;
    localparam logic WB_MEM = 1'b1;

endpackage

// File: rtl/stage4_mem_writeback_mem_handshake.sv
// Data-memory req/ack engine: owns the mem_* outputs, the MDR and (with
// MEM_TIMEOUT_EN) the REQ-cycle timeout counter; reports done/abort upward.
module mem_handshake
    import stage4_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
`ifdef MEM_TIMEOUT_EN
    , parameter int TIMEOUT = TIMEOUT_DEF
`endif
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              launch,
    input  logic              launchWe,
    input  logic [ADDR_W-1:0] launchAddr,
    input  logic [DATA_W-1:0] launchWdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              done,
    output logic              abort,
    output logic [DATA_W-1:0] mdr,
    output logic [DATA_W-1:0] mdrNext
);

    // Handshake: mem_req rises the cycle after launch and holds mem_addr,
    // mem_we and mem_wdata stable until mem_ack is sampled high while
    // mem_req=1; a completing ack may arrive in the very first request cycle,
    // and an ack seen while mem_req=0 is ignored.
    assign done    = mem_req && mem_ack;
    assign mdrNext = (done && !mem_we) ? mem_rdata : mdr;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mdr       <= '0;
        end else if (launch) begin
            mem_req   <= 1'b1;
            mem_we    <= launchWe;
            mem_addr  <= launchAddr;
            mem_wdata <= launchWdata;
        end else if (done) begin
            mem_req <= 1'b0;
            if (!mem_we) begin
                mdr <= mem_rdata;
            end
        end else if (abort) begin
            mem_req <= 1'b0;
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] reqCnt;

    // Counts completed request cycles; an ack in the expiring cycle still wins.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            reqCnt <= '0;
        end else if (launch) begin
            reqCnt <= '0;
        end else if (mem_req) begin
            reqCnt <= reqCnt + 1'b1;
        end
    end

    assign abort = mem_req && !mem_ack && (reqCnt == CNT_W'(TIMEOUT - 1));
`else
    assign abort = 1'b0;
`endif

endmodule

// File: rtl/stage4_mem_writeback.sv
// Stage-4 memory access / register writeback with IDLE->REQ->WB sequencing.
// Define MEM_TIMEOUT_EN to add the request timeout and the sticky MemErr port.
module stage4_mem_writeback
    import stage4_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int RA_W   = RA_W_DEF
`ifdef MEM_TIMEOUT_EN
    , parameter int TIMEOUT = TIMEOUT_DEF
`endif
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              Start,
    input  logic [DATA_W-1:0] ResIn,
    input  logic [DATA_W-1:0] StoreData,
    input  logic [RA_W-1:0]   DestReg,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              RegWrite,
    input  logic              WBSource,
    output logic              Busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              RegWEn,
    output logic [RA_W-1:0]   RegWAddr,
    output logic [DATA_W-1:0] RegWData,
    output state_t            dbgState
`ifdef MEM_TIMEOUT_EN
    , output logic            MemErr
`endif
);

    state_t            state;
    logic [DATA_W-1:0] resLat;
    logic [RA_W-1:0]   destLat;
    logic              regWriteLat;
    logic              wbSrcLat;

    logic              isMemOp;
    logic              hsLaunch;
    logic              hsDone;
    logic              hsAbort;
    logic [DATA_W-1:0] hsMdr;
    logic [DATA_W-1:0] hsMdrNext;

    assign isMemOp  = MemRead || MemWrite;
    assign hsLaunch = (state == IDLE) && Start && isMemOp;
    assign Busy     = (state != IDLE);
    assign dbgState = state;

    mem_handshake #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
`ifdef MEM_TIMEOUT_EN
        , .TIMEOUT (TIMEOUT)
`endif
    ) u_mem_handshake (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .launch      (hsLaunch),
        .launchWe    (MemWrite),
        .launchAddr  (ResIn[ADDR_W-1:0]),
        .launchWdata (StoreData),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .done        (hsDone),
        .abort       (hsAbort),
        .mdr         (hsMdr),
        .mdrNext     (hsMdrNext)
    );

    // RegW* are loaded on entry to WB, so the load path forwards the MDR value
    // being captured on the same edge rather than the stale one.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            RegWEn      <= 1'b0;
            RegWAddr    <= '0;
            RegWData    <= '0;
            resLat      <= '0;
            destLat     <= '0;
            regWriteLat <= 1'b0;
            wbSrcLat    <= WB_RES;
`ifdef MEM_TIMEOUT_EN
            MemErr      <= 1'b0;
`endif
        end else begin
            RegWEn <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        resLat      <= ResIn;
                        destLat     <= DestReg;
                        regWriteLat <= RegWrite;
                        // A combined read+write is a store; its writeback uses ResIn.
                        wbSrcLat    <= (MemRead && MemWrite) ? WB_RES : WBSource;
`ifdef MEM_TIMEOUT_EN
                        MemErr      <= 1'b0;
`endif
                        if (isMemOp) begin
                            state <= REQ;
                        end else begin
                            state    <= WB;
                            RegWEn   <= RegWrite;
                            RegWAddr <= DestReg;
                            RegWData <= (WBSource == WB_MEM) ? hsMdr : ResIn;
                        end
                    end
                end
                REQ: begin
                    if (hsDone) begin
                        state    <= WB;
                        RegWEn   <= regWriteLat;
                        RegWAddr <= destLat;
                        RegWData <= (wbSrcLat == WB_MEM) ? hsMdrNext : resLat;
                    end else if (hsAbort) begin
                        state <= IDLE;
`ifdef MEM_TIMEOUT_EN
                        MemErr <= 1'b1;
`endif
                    end
                end
                WB: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage4_mem_writeback.sv
// Self-checking bench for stage4_mem_writeback (timeout steps run only when
// MEM_TIMEOUT_EN is defined).
module tb_stage4_mem_writeback;
    import stage4_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        Start = 1'b0;
    logic [15:0] ResIn = '0;
    logic [15:0] StoreData = '0;
    logic [3:0]  DestReg = '0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic        RegWrite = 1'b0;
    logic        WBSource = 1'b0;
    logic        Busy;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        RegWEn;
    logic [3:0]  RegWAddr;
    logic [15:0] RegWData;
    state_t      dbgState;
`ifdef MEM_TIMEOUT_EN
    logic        MemErr;
`endif

    int tests = 0;
    int fails = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mdrModel = '0;

    stage4_mem_writeback dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .Start     (Start),
        .ResIn     (ResIn),
        .StoreData (StoreData),
        .DestReg   (DestReg),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .RegWrite  (RegWrite),
        .WBSource  (WBSource),
        .Busy      (Busy),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .RegWEn    (RegWEn),
        .RegWAddr  (RegWAddr),
        .RegWData  (RegWData),
        .dbgState  (dbgState)
`ifdef MEM_TIMEOUT_EN
        , .MemErr  (MemErr)
`endif
    );

    // Clock / reset
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_junk(input logic junk);
        Start = junk;
        if (junk) begin
            ResIn     = 16'($urandom);
            StoreData = 16'($urandom);
            DestReg   = 4'($urandom);
            MemRead   = 1'($urandom);
            MemWrite  = 1'($urandom);
            RegWrite  = 1'($urandom);
            WBSource  = 1'($urandom);
        end
    endtask

    // One complete operation from a negedge in IDLE back to IDLE. The memory
    // acks after waitN wait cycles; junk keeps Start high while the stage is busy.
    task automatic do_op(input string name, input logic [15:0] res, input logic [15:0] sd,
                         input logic [3:0] dst, input logic rd, input logic wr,
                         input logic rw, input logic wbs, input int waitN,
                         input logic [15:0] rdata, input logic junk);
        logic        isMem;
        logic        useMem;
        logic [15:0] expData;
        isMem  = rd | wr;
        useMem = (rd && wr) ? 1'b0 : wbs;
        if (rd && !wr) mdrModel = rdata;
        expData = useMem ? mdrModel : res;
        if (rw) exp_q.push_back(expData);

        Start = 1'b1; ResIn = res; StoreData = sd; DestReg = dst;
        MemRead = rd; MemWrite = wr; RegWrite = rw; WBSource = wbs;
        @(negedge CLK);
        drive_junk(junk);
        if (isMem) begin
            for (int i = 0; i <= waitN; i++) begin
                check($sformatf("%s req[%0d]", name, i), mem_req, 1);
                check($sformatf("%s busy_req[%0d]", name, i), Busy, 1);
                check($sformatf("%s addr[%0d]", name, i), mem_addr, res);
                check($sformatf("%s we[%0d]", name, i), mem_we, wr);
                if (wr) check($sformatf("%s wdata[%0d]", name, i), mem_wdata, sd);
                check($sformatf("%s wen_req[%0d]", name, i), RegWEn, 0);
                mem_ack   = (i == waitN);
                mem_rdata = (i == waitN) ? rdata : 16'($urandom);
                @(negedge CLK);
                mem_ack = 1'b0;
                drive_junk(junk);
            end
        end
        check({name, " busy_wb"}, Busy, 1);
        check({name, " req_wb"}, mem_req, 0);
        check({name, " wen"}, RegWEn, rw);
        if (rw) begin
            check({name, " waddr"}, RegWAddr, dst);
            check({name, " wdata"}, RegWData, exp_q.pop_front());
        end
        @(negedge CLK);
        Start = 1'b0;
        check({name, " busy_done"}, Busy, 0);
        check({name, " wen_done"}, RegWEn, 0);
        check({name, " state_done"}, dbgState, IDLE);
    endtask

    initial begin
        // Reset state
        RST_N = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check("rst busy", Busy, 0);
        check("rst req", mem_req, 0);
        check("rst we", mem_we, 0);
        check("rst addr", mem_addr, 0);
        check("rst wdata", mem_wdata, 0);
        check("rst wen", RegWEn, 0);
        check("rst waddr", RegWAddr, 0);
        check("rst wdata_reg", RegWData, 0);
        check("rst state", dbgState, IDLE);
        RST_N = 1'b1;
        @(negedge CLK);

        // ALU writeback, load with waits, zero-wait store
        do_op("alu", 16'h1234, 16'h0000, 4'd3, 0, 0, 1, 0, 0, 16'h0000, 0);
        do_op("load", 16'h0040, 16'h0000, 4'd5, 1, 0, 1, 1, 2, 16'hBEEF, 0);
        do_op("store", 16'h0010, 16'h00AA, 4'd7, 0, 1, 0, 0, 0, 16'h0000, 0);
        do_op("stale_mdr", 16'h5555, 16'h0000, 4'd9, 0, 0, 1, 1, 0, 16'h0000, 0);
        do_op("rd_wr", 16'h0020, 16'h1111, 4'd2, 1, 1, 1, 1, 1, 16'h7777, 0);
        do_op("after_rdwr", 16'h0001, 16'h0000, 4'd4, 0, 0, 1, 1, 0, 16'h0000, 0);

        // Stray ack in IDLE and Start while busy
        mem_ack = 1'b1;
        mem_rdata = 16'hDEAD;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check($sformatf("stray req[%0d]", i), mem_req, 0);
            check($sformatf("stray wen[%0d]", i), RegWEn, 0);
            check($sformatf("stray busy[%0d]", i), Busy, 0);
        end
        mem_ack = 1'b0;
        do_op("busy_start", 16'h0300, 16'h0BCD, 4'd6, 1, 0, 1, 1, 1, 16'hCAFE, 1);
        @(negedge CLK);
        check("busy_start idle_req", mem_req, 0);
        check("busy_start idle_wen", RegWEn, 0);
        check("busy_start idle_busy", Busy, 0);

        // Randomised operations against the reference model
        for (int n = 0; n < 40; n++) begin
            do_op($sformatf("rnd%0d", n), 16'($urandom), 16'($urandom), 4'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 3)), 16'($urandom), 1'($urandom));
        end

        // Asynchronous reset in the middle of a request
        Start = 1'b1; ResIn = 16'h0080; DestReg = 4'd1;
        MemRead = 1'b1; MemWrite = 1'b0; RegWrite = 1'b1; WBSource = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        check("midrst req_before", mem_req, 1);
        #2 RST_N = 1'b0;
        #1;
        check("midrst req", mem_req, 0);
        check("midrst busy", Busy, 0);
        check("midrst wen", RegWEn, 0);
        mdrModel = '0;
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        check("midrst state", dbgState, IDLE);
        check("midrst wen_after", RegWEn, 0);
        check("midrst req_after", mem_req, 0);
        do_op("mdr_cleared", 16'h4321, 16'h0000, 4'd8, 0, 0, 1, 1, 0, 16'h0000, 0);

`ifdef MEM_TIMEOUT_EN
        begin
            int reqCycles;
            int wenSeen;
            reqCycles = 0;
            wenSeen = 0;
            Start = 1'b1; ResIn = 16'h0100; DestReg = 4'd2;
            MemRead = 1'b1; MemWrite = 1'b0; RegWrite = 1'b1; WBSource = 1'b1;
            @(negedge CLK);
            Start = 1'b0;
            while (mem_req && reqCycles < 40) begin
                reqCycles++;
                if (RegWEn) wenSeen++;
                @(negedge CLK);
            end
            check("tmo cycles", reqCycles, 15);
            check("tmo req", mem_req, 0);
            check("tmo err", MemErr, 1);
            check("tmo busy", Busy, 0);
            @(negedge CLK);
            if (RegWEn) wenSeen++;
            check("tmo no_wen", wenSeen, 0);
            check("tmo err_sticky", MemErr, 1);
            do_op("tmo_clear", 16'h0222, 16'h0000, 4'd3, 0, 0, 1, 0, 0, 16'h0000, 0);
            check("tmo err_cleared", MemErr, 0);
            do_op("tmo_edge_ack", 16'h0333, 16'h0000, 4'd4, 1, 0, 1, 1, 14, 16'h9A9A, 0);
            check("tmo edge_err", MemErr, 0);
        end
`endif

        if (exp_q.size() != 0) begin
            check("scoreboard drained", exp_q.size(), 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stage4_mem_writeback.md
Name: stage4_mem_writeback

Overview:
Memory-access / register-writeback stage sitting directly downstream of the stage-3 ALU/shifter result register.
- Consumes the 16-bit result (ResIn) as a memory address or as writeback data.
- Runs a req/ack handshake to data memory and produces a single-cycle register-file write.
- Stalls upstream via Busy while a transaction is in flight.

Parameters:
DATA_W, 16, data/result width
ADDR_W, 16, memory address width (low ADDR_W bits of ResIn)
RA_W, 4, register-file address width
TIMEOUT, 15, max REQ cycles without ack before abort (used only with the optional feature)

Ports:
CLK  in  1  rising-edge clock (single clock domain)
RST_N  in  1  asynchronous active-low reset
Start  in  1  operation valid; accepted only in IDLE
ResIn  in  DATA_W  stage-3 result: address or writeback data
StoreData  in  DATA_W  store data for memory writes
DestReg  in  RA_W  destination register
MemRead  in  1  load operation
MemWrite  in  1  store operation
RegWrite  in  1  writeback requested
WBSource  in  1  0 = ResIn, 1 = loaded memory data
Busy  out  1  stage occupied; upstream must hold
mem_req  out  1  memory request
mem_we  out  1  1 = write, 0 = read; valid while mem_req
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  read data; valid with mem_ack
mem_ack  in  1  memory completion
RegWEn  out  1  register-file write strobe (one cycle)
RegWAddr  out  RA_W  register-file write address
RegWData  out  DATA_W  register-file write data
MemErr  out  1  sticky timeout flag; port exists only with MEM_TIMEOUT_EN

Behaviour:
- Reset (async, RST_N=0):
  - state=IDLE.
  - All outputs 0.
  - Latched operands and MDR cleared.
  - Reset mid-transaction drops mem_req immediately; no writeback occurs.
- FSM states: IDLE, REQ, WB.
  - IDLE: Start=1 latches ResIn, StoreData, DestReg, RegWrite, WBSource and the op type.
    - If MemRead or MemWrite: next state REQ.
    - Otherwise: next state WB.
  - REQ:
    - Drives mem_req=1 plus stable mem_addr/mem_we/mem_wdata until mem_ack is sampled 1.
    - On ack: a read loads mem_rdata into the MDR; next state WB.
  - WB:
    - RegWEn=latched RegWrite for exactly one cycle.
    - RegWAddr=latched DestReg.
    - RegWData = WBSource ? MDR : latched ResIn.
    - Next state IDLE.
- Busy = (state != IDLE). Start while Busy is ignored.
- mem_ack outside REQ is ignored.
- Ack is allowed in the first REQ cycle (zero-wait memory).
- Latency:
  - Non-memory op: Start at cycle N gives RegWEn at N+1.
  - Memory op with zero-wait ack: Start at N, mem_req at N+1, RegWEn at N+2.
  - Each wait cycle adds one cycle.
- MemRead=MemWrite=1: treated as a write; WBSource forced to 0; MDR unchanged.
- WBSource=1 with no MemRead: writes the stale MDR (defined, not an error).
- RegWrite=0: the WB cycle still occurs (Busy high) with RegWEn=0.
- Outputs mem_*, RegW* are registered; RegWData/RegWAddr hold their values outside WB. Only the strobes are pulsed.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - A cycle counter runs in REQ.
  - After TIMEOUT consecutive REQ cycles without ack, the stage aborts: mem_req drops, no writeback, return to IDLE, MemErr set.
  - MemErr clears on reset or on the next accepted Start.
  - Ack in the same cycle the counter expires wins (normal completion).
- Undefined: REQ waits indefinitely; no counter and no MemErr port.

Decomposition:
- Package stage4_pkg holds:
  - state encoding: IDLE=2'd0, REQ=2'd1, WB=2'd2;
  - WBSource constants WB_RES=1'b0, WB_MEM=1'b1;
  - default widths.
- One sub-module, mem_handshake: owns mem_req/mem_we/mem_addr/mem_wdata, MDR capture and the optional timeout counter. It reports done/abort to the top-level FSM.

Test Plan:
1. Reset: RST_N=0 mid-REQ, mem_req=1 -> mem_req, Busy, RegWEn go 0 asynchronously; after release, state IDLE.
2. ALU writeback: Start with ResIn=16'h1234, DestReg=3, RegWrite=1, no mem op -> next cycle RegWEn=1, RegWAddr=3, RegWData=16'h1234; Busy high for exactly 1 cycle.
3. Load, 3-cycle wait: ResIn=16'h0040, MemRead=1, WBSource=1; ack on 3rd REQ cycle with rdata=16'hBEEF -> mem_addr=16'h0040, mem_we=0 held 3 cycles; RegWData=16'hBEEF one cycle later.
4. Store, zero-wait: MemWrite=1, ResIn=16'h0010, StoreData=16'h00AA, RegWrite=0; ack in first REQ cycle -> mem_we=1, mem_wdata=16'h00AA; WB cycle with RegWEn=0; Busy for 2 cycles.
5. Start asserted while Busy, and stray mem_ack in IDLE -> both ignored; no extra mem_req or RegWEn.
6. MEM_TIMEOUT_EN, TIMEOUT=15: read with no ack -> mem_req drops after 15 cycles, MemErr=1, no RegWEn; next Start clears MemErr.
